// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared definitions for the multicycle RV32I main controller.
// Holds the opcode constants, the alu_op encoding shared with the ALU control
// decoder, the datapath mux-select encodings and the controller state enum.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;

  localparam int STATE_W = 4;

  // Encoding understood by the ALU control decoder.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_TRAP    = 4'd10
  } state_e;

endpackage

// File: rtl/mc_retire_cnt.sv
// mc_retire_cnt: wrapping up-counter of retired instructions.
// Ports:
//   clk    in  clock
//   clr_n  in  synchronous active-low clear
//   inc    in  add one this cycle
//   count  out current count, wraps modulo 2^W
module mc_retire_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle RV32I main controller. A Moore FSM sequences each
// instruction, drives alu_op into the ALU control decoder and steers every
// datapath mux/enable. It also counts retired instructions and traps on
// unknown opcodes.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   opcode              instr[6:0] from the IR (valid from DECODE onward)
//   zero                ALU zero flag
//   mem_ready           memory completed the current request
//   mem_req/mem_we      memory request valid / write
//   adr_src             memory address: 0 = PC, 1 = ALUOut
//   ir_write, pc_write  IR (+oldPC) load, PC load
//   reg_write           register file write enable
//   alu_src_a/b, result_src, imm_src, alu_op   datapath selects
//   illegal_instr       sticky illegal-opcode flag
//   instr_retired       one-cycle pulse per completed instruction
//   retired_count       retired-instruction count
//   dbg_state           current FSM state (observation only)
//
// Memory handshake: a request is live while mem_req=1; address and mem_we are
// held stable until the cycle in which mem_ready=1 completes it. mem_ready seen
// while mem_req=0 has no effect.
module mc_main_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       dbg_state
);

  state_e      state_q, state_d;
  logic        illegal_q;

  logic        mem_req_c, mem_we_c, adr_src_c, ir_write_c, pc_write_c;
  logic        reg_write_c, retired_c;
  src_a_e      src_a_c;
  src_b_e      src_b_c;
  result_src_e result_c;
  imm_src_e    imm_c;
  alu_op_e     alu_op_c;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // TRAP is absorbing, so setting on entry keeps the flag sticky.
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    adr_src_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    retired_c   = 1'b0;
    src_a_c     = SRC_A_PC;
    src_b_c     = SRC_B_RS2;
    result_c    = RES_ALUOUT;
    imm_c       = IMM_I;
    alu_op_c    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        src_b_c    = SRC_B_FOUR;
        result_c   = RES_ALU;
        // PC+4 is written back in the same cycle the instruction arrives.
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        src_a_c = SRC_A_OLDPC;
        src_b_c = SRC_B_IMM;
        imm_c   = IMM_B;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ITYPE:     state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        src_a_c = SRC_A_RS1;
        src_b_c = SRC_B_IMM;
        if (opcode == OP_SW) begin
          imm_c   = IMM_S;
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        result_c    = RES_MEMDATA;
        retired_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src_c = 1'b1;
        retired_c = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        src_a_c  = SRC_A_RS1;
        src_b_c  = SRC_B_RS2;
        alu_op_c = ALU_RTYPE;
        state_d  = S_ALU_WB;
      end
      S_EXEC_I: begin
        src_a_c  = SRC_A_RS1;
        src_b_c  = SRC_B_IMM;
        imm_c    = IMM_I;
        alu_op_c = ALU_ITYPE;
        state_d  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        result_c    = RES_ALUOUT;
        retired_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = SRC_A_RS1;
        src_b_c    = SRC_B_RS2;
        alu_op_c   = ALU_SUB;
        result_c   = RES_ALUOUT;
        pc_write_c = zero;
        retired_c  = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  mc_retire_cnt #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (retired_c & rst_n),
    .count (count)
  );

  // Every output is held at zero while reset is asserted, including the
  // FETCH request that state_q would otherwise imply.
  assign mem_req       = rst_n & mem_req_c;
  assign mem_we        = rst_n & mem_we_c;
  assign adr_src       = rst_n & adr_src_c;
  assign ir_write      = rst_n & ir_write_c;
  assign pc_write      = rst_n & pc_write_c;
  assign reg_write     = rst_n & reg_write_c;
  assign instr_retired = rst_n & retired_c;
  assign illegal_instr = rst_n & illegal_q;
  assign alu_src_a     = rst_n ? src_a_c  : 2'b00;
  assign alu_src_b     = rst_n ? src_b_c  : 2'b00;
  assign result_src    = rst_n ? result_c : 2'b00;
  assign imm_src       = rst_n ? imm_c    : 2'b00;
  assign alu_op        = rst_n ? alu_op_c : 2'b00;
  assign retired_count = rst_n ? count    : '0;
  assign dbg_state     = rst_n ? state_q  : 4'd0;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: testbench for mc_main_ctrl. Each instruction is expanded
// into a per-cycle list of stimulus and expected control words, built from the
// phase sequence of its instruction class.
module tb_mc_main_ctrl;

  localparam int CNT_W = 2;
  localparam int W     = 18;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src, imm_src, alu_op;
  logic             illegal_instr, instr_retired;
  logic [CNT_W-1:0] retired_count;
  logic [3:0]       dbg_state;

  mc_main_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .imm_src       (imm_src),
    .alu_op        (alu_op),
    .illegal_instr (illegal_instr),
    .instr_retired (instr_retired),
    .retired_count (retired_count),
    .dbg_state     (dbg_state)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;

  typedef struct {
    logic       rst_n;
    logic       rdy;
    logic [6:0] op;
    logic       zero;
  } stim_t;

  stim_t        stim_q[$];
  logic [W-1:0] exp_q[$];

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // {illegal, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
  //  instr_retired, alu_src_a, alu_src_b, result_src, imm_src, alu_op}
  function automatic logic [W-1:0] ctl(input logic ill, req, we, adr, irw, pcw, rw, ret,
                                       input logic [1:0] a, b, res, imm, op);
    return {ill, req, we, adr, irw, pcw, rw, ret, a, b, res, imm, op};
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic push(input logic r, input logic rdy, input logic [6:0] op,
                      input logic z, input logic [W-1:0] w);
    stim_t s;
    s.rst_n = r; s.rdy = rdy; s.op = op; s.zero = z;
    stim_q.push_back(s);
    exp_q.push_back(w);
  endtask

  // Noise on mem_ready/zero in cycles where they must not matter.
  task automatic push_n(input logic [6:0] op, input logic [W-1:0] w);
    push(1'b1, 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), w);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, 1'($urandom_range(0, 1)), rnd_op(), 1'($urandom_range(0, 1)), '0);
  endtask

  task automatic add_fetch(input int waits);
    for (int i = 0; i < waits; i++)
      push(1'b1, 1'b0, rnd_op(), 1'($urandom_range(0, 1)),
           ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00));
    push(1'b1, 1'b1, rnd_op(), 1'($urandom_range(0, 1)),
         ctl(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00));
  endtask

  // Full instruction: fetch, decode, then the class-specific phases.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic z, input int trap_cycles);
    add_fetch(fw);
    push_n(op, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
    case (op)
      LW: begin
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00));
        for (int i = 0; i <= mw; i++)
          push(1'b1, (i == mw), op, 1'($urandom_range(0, 1)),
               ctl(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
      end
      SW: begin
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00));
        for (int i = 0; i <= mw; i++)
          push(1'b1, (i == mw), op, 1'($urandom_range(0, 1)),
               ctl(0, 1, 1, 1, 0, 0, 0, (i == mw), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      RT: begin
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      IT: begin
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11));
        push_n(op, ctl(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      BEQ: begin
        push(1'b1, 1'($urandom_range(0, 1)), op, z,
             ctl(0, 0, 0, 0, 0, z, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01));
      end
      default: begin
        for (int i = 0; i < trap_cycles; i++)
          push_n(op, ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      end
    endcase
  endtask

  // driver: one queued step per clock
  task automatic run_queue();
    stim_t        s;
    logic [W-1:0] e;
    logic [W-1:0] act;
    int           cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst_n = s.rst_n; mem_ready = s.rdy; opcode = s.op; zero = s.zero;
      @(negedge clk);
      act = {illegal_instr, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             instr_retired, alu_src_a, alu_src_b, result_src, imm_src, alu_op};
      check($sformatf("ctl@%0d", cyc), 32'(act), 32'(e));
      check($sformatf("cnt@%0d", cyc), 32'(retired_count),
            s.rst_n ? 32'(model_cnt) : 32'd0);
      if (!s.rst_n)    model_cnt = 0;
      else if (e[10])  model_cnt = (model_cnt + 1) % (1 << CNT_W);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] legal [5];
    logic [6:0] bad   [4];
    legal[0] = LW; legal[1] = SW; legal[2] = RT; legal[3] = IT; legal[4] = BEQ;
    bad[0] = 7'b1111111; bad[1] = 7'b0000000; bad[2] = 7'b1101111; bad[3] = 7'b0110111;

    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;

    // directed: reset, add, lw with 3 waits, beq taken/not, sw with 2 waits
    add_reset(2);
    add_instr(RT, 0, 0, 1'b0, 0);
    add_instr(LW, 0, 3, 1'b0, 0);
    add_instr(BEQ, 0, 0, 1'b1, 0);
    add_instr(BEQ, 0, 0, 1'b0, 0);
    add_instr(SW, 0, 2, 1'b0, 0);
    add_instr(IT, 1, 0, 1'b0, 0);
    run_queue();

    // random legal instruction stream with random memory latency
    for (int n = 0; n < 40; n++)
      add_instr(legal[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 0);
    run_queue();

    // reset while MEM_RD waits, with mem_ready pulsing during reset
    add_fetch(0);
    push_n(LW, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
    push_n(LW, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 2; i++)
      push(1'b1, 1'b0, LW, 1'b0, ctl(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push(1'b0, 1'b1, LW, 1'b0, '0);
    // four retirements wrap the 2-bit count back to 0
    for (int n = 0; n < 4; n++) add_instr(n[0] ? IT : RT, 0, 0, 1'b0, 0);
    run_queue();

    // illegal opcodes: trap, sticky flag, recovery through reset
    add_instr(7'b1111111, 0, 0, 1'b0, 5);
    add_reset(1);
    add_instr(RT, 0, 0, 1'b0, 0);
    add_instr(bad[$urandom_range(0, 3)], $urandom_range(0, 2), 0, 1'b0, 3);
    add_reset(1);
    add_instr(BEQ, 0, 0, 1'b1, 0);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
